execute_stage_pipe: RTL

Parametrised, registered EX stage for the MIPS datapath. Adds valid/ready handshakes on both sides and an EX/MEM output register. Also adds an iterative multiplier (mult/multu) that writes HI/LO, with mfhi/mflo reads. It sits between the ID/EX register and the memory stage and holds the pipeline while a multiply is in progress.

---
 rtl/execute_stage_pipe.sv | 183 ++++++++++++++++++
 1 files changed

// File: rtl/execute_stage_pipe.sv
// Registered EX stage: ALU, branch target, valid/ready handshakes and an
// iterative shift-add multiplier feeding HI/LO.
module execute_stage_pipe #(
  parameter int XLEN     = 32,
  parameter int RA_W     = 5,
  parameter int SHAMT_BR = 2
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic            alu_src,
  input  logic [1:0]      alu_op,
  input  logic            reg_dst,
  input  logic [XLEN-1:0] pc_next,
  input  logic [XLEN-1:0] branch_imm,
  input  logic [XLEN-1:0] rs_data,
  input  logic [XLEN-1:0] rt_data,
  input  logic [RA_W-1:0] rt,
  input  logic [RA_W-1:0] rd,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] pc_branch,
  output logic            alu_zero,
  output logic [XLEN-1:0] alu_res,
  output logic [RA_W-1:0] write_reg,
  output logic            busy
);

  localparam int CW = (XLEN > 1) ? $clog2(XLEN) : 1;

  typedef enum logic [1:0] {
    S_IDLE,
    S_MUL,
    S_DONE
  } state_e;

  state_e state_q, state_d;

  logic [XLEN-1:0]   b_op, res_c, pcb_c;
  logic [RA_W-1:0]   wr_c;
  logic [5:0]        funct;
  logic              is_mul, is_sgn;
  logic              in_fire, out_free, mul_last;
  logic [XLEN-1:0]   mag_a, mag_b;

  logic [2*XLEN-1:0] acc_q, mcand_q, acc_nx, prod;
  logic [XLEN-1:0]   mplier_q, hi_q, lo_q;
  logic [CW-1:0]     cnt_q;
  logic              neg_q;
  logic [XLEN-1:0]   mpcb_q;

  logic              ov_q;
  logic [XLEN-1:0]   res_q, pcb_q;
  logic [RA_W-1:0]   wr_q;
  logic              zero_q;

  assign b_op  = alu_src ? branch_imm : rt_data;
  assign funct = branch_imm[5:0];
  assign pcb_c = pc_next + (branch_imm << SHAMT_BR);

  always_comb begin
    res_c  = '0;
    wr_c   = reg_dst ? rd : rt;
    is_mul = 1'b0;
    is_sgn = 1'b0;
    case (alu_op)
      2'b00: res_c = rs_data + b_op;
      2'b01: res_c = rs_data - b_op;
      2'b11: res_c = rs_data | b_op;
      default: begin
        case (funct)
          6'b100000: res_c = rs_data + b_op;
          6'b100010: res_c = rs_data - b_op;
          6'b100100: res_c = rs_data & b_op;
          6'b100101: res_c = rs_data | b_op;
          6'b100111: res_c = ~(rs_data | b_op);
          6'b101010: res_c = {{(XLEN-1){1'b0}},
                              $signed(rs_data) < $signed(b_op)};
          6'b010000: res_c = hi_q;
          6'b010010: res_c = lo_q;
          6'b011000: begin
            is_mul = 1'b1;
            is_sgn = 1'b1;
            wr_c   = '0;
          end
          6'b011001: begin
            is_mul = 1'b1;
            wr_c   = '0;
          end
          default: wr_c = '0;
        endcase
      end
    endcase
  end

  assign out_free = !ov_q | out_ready;
  assign in_fire  = in_valid & in_ready;
  assign mul_last = (cnt_q == CW'(XLEN-1));

  assign mag_a = (is_sgn & rs_data[XLEN-1]) ? -rs_data : rs_data;
  assign mag_b = (is_sgn & b_op[XLEN-1]) ? -b_op : b_op;
  assign acc_nx = acc_q + (mplier_q[0] ? mcand_q : '0);
  assign prod   = neg_q ? -acc_nx : acc_nx;

  always_ff @(posedge clk) begin
    if (rst) state_q <= S_IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE: if (in_fire && is_mul) state_d = S_MUL;
      S_MUL:  if (mul_last)          state_d = S_DONE;
      S_DONE: if (out_free)          state_d = S_IDLE;
      default:                       state_d = S_IDLE;
    endcase
  end

  // DONE owns the output register for its result word, so no intake there
  always_comb begin
    busy     = (state_q == S_MUL);
    in_ready = (state_q == S_IDLE) & out_free;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      acc_q    <= '0;
      mcand_q  <= '0;
      mplier_q <= '0;
      cnt_q    <= '0;
      neg_q    <= 1'b0;
      mpcb_q   <= '0;
      hi_q     <= '0;
      lo_q     <= '0;
    end else if (state_q == S_IDLE && in_fire && is_mul) begin
      acc_q    <= '0;
      mcand_q  <= {{XLEN{1'b0}}, mag_a};
      mplier_q <= mag_b;
      cnt_q    <= '0;
      neg_q    <= is_sgn & (rs_data[XLEN-1] ^ b_op[XLEN-1]);
      mpcb_q   <= pcb_c;
    end else if (state_q == S_MUL) begin
      acc_q    <= acc_nx;
      mcand_q  <= mcand_q << 1;
      mplier_q <= mplier_q >> 1;
      cnt_q    <= cnt_q + 1'b1;
      if (mul_last) {hi_q, lo_q} <= prod;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ov_q   <= 1'b0;
      res_q  <= '0;
      pcb_q  <= '0;
      wr_q   <= '0;
      zero_q <= 1'b0;
    end else if (state_q == S_DONE && out_free) begin
      ov_q   <= 1'b1;
      res_q  <= lo_q;
      pcb_q  <= mpcb_q;
      wr_q   <= '0;
      zero_q <= (lo_q == '0);
    end else if (in_fire && !is_mul) begin
      ov_q   <= 1'b1;
      res_q  <= res_c;
      pcb_q  <= pcb_c;
      wr_q   <= wr_c;
      zero_q <= (res_c == '0);
    end else if (out_ready) begin
      ov_q   <= 1'b0;
    end
  end

  assign out_valid = ov_q;
  assign alu_res   = res_q;
  assign pc_branch = pcb_q;
  assign write_reg = wr_q;
  assign alu_zero  = zero_q;

endmodule
